// File: rtl/axis_pkt_arbiter_if.sv
// Bundle of NUM_PORTS AXI-Stream source channels plus one merged output channel.
// The arbiter connects through the slave modport. The sources and the sink connect through the master modport.
interface axis_pkt_arbiter_if #(
   parameter int AXIS_DW   = 64,
   parameter int NUM_PORTS = 4
) ();
   localparam int AXIS_KW = ((AXIS_DW - 1) >> 3) + 1;

   // Handshake: a beat moves on a rising clk edge where tvalid and tready are both high;
   // tdata/tkeep/tlast are only meaningful while tvalid is high.
   logic [NUM_PORTS-1:0]         s_axis_tvalid;
   logic [NUM_PORTS-1:0]         s_axis_tready;
   logic [NUM_PORTS*AXIS_DW-1:0] s_axis_tdata;
   logic [NUM_PORTS*AXIS_KW-1:0] s_axis_tkeep;
   logic [NUM_PORTS-1:0]         s_axis_tlast;
   logic                         m_axis_tvalid;
   logic                         m_axis_tready;
   logic [AXIS_DW-1:0]           m_axis_tdata;
   logic [AXIS_KW-1:0]           m_axis_tkeep;
   logic                         m_axis_tlast;

   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
   );

   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
   );
endinterface

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: locks one AXIS source for a whole packet and
// forwards its beats untouched, with one idle cycle between packets.
module axis_pkt_arbiter #(
   parameter int AXIS_DW   = 64,
   parameter int NUM_PORTS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   axis_pkt_arbiter_if.slave            bus,
   output logic [$clog2(NUM_PORTS)-1:0] grant_id,
   output logic                         busy
);
   localparam int AXIS_KW = ((AXIS_DW - 1) >> 3) + 1;
   localparam int IDW     = $clog2(NUM_PORTS);

   typedef enum logic {IDLE, XFER} state_t;

   state_t         state;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] grant;
   logic [IDW-1:0] next_grant;
   logic           active;

   // Outputs drop to their idle values as soon as rst is seen, not one edge later.
   assign active   = (state == XFER) && !rst;
   assign busy     = active;
   assign grant_id = rst ? IDW'(NUM_PORTS - 1) : (active ? grant : last_grant);

   // Rank each port by its distance after last_grant; the nearest requester wins.
   always_comb begin : rr_pick
      int best_d;
      int d;
      best_d     = NUM_PORTS;
      d          = 0;
      next_grant = last_grant;
      for (int i = 0; i < NUM_PORTS; i++) begin
         d = (i + 2 * NUM_PORTS - 1 - int'(last_grant)) % NUM_PORTS;
         if (bus.s_axis_tvalid[i] && (d < best_d)) begin
            best_d     = d;
            next_grant = IDW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= IDW'(NUM_PORTS - 1);
         grant      <= IDW'(NUM_PORTS - 1);
      end else begin
         case (state)
            IDLE: begin
               if (|bus.s_axis_tvalid) begin
                  grant <= next_grant;
                  state <= XFER;
               end
            end
            XFER: begin
               if (bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast) begin
                  last_grant <= grant;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The granted port is wired straight through; tkeep is never inspected.
   always_comb begin
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tdata  = '0;
      bus.m_axis_tkeep  = '0;
      bus.m_axis_tlast  = 1'b0;
      bus.s_axis_tready = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant == IDW'(i)) begin
            bus.m_axis_tdata = bus.s_axis_tdata[i*AXIS_DW +: AXIS_DW];
            bus.m_axis_tkeep = bus.s_axis_tkeep[i*AXIS_KW +: AXIS_KW];
            if (active) begin
               bus.m_axis_tvalid    = bus.s_axis_tvalid[i];
               bus.m_axis_tlast     = bus.s_axis_tlast[i];
               bus.s_axis_tready[i] = bus.m_axis_tready;
            end
         end
      end
   end
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Randomised and directed bench for axis_pkt_arbiter against a packet-level
// round-robin reference model with an expected-beat scoreboard.
module tb_axis_pkt_arbiter;
   localparam int DW  = 64;
   localparam int NP  = 4;
   localparam int KW  = ((DW - 1) >> 3) + 1;
   localparam int IDW = $clog2(NP);
   localparam int BW  = DW + KW + 1;

   // ---------------- clock / reset / DUT ----------------
   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [IDW-1:0] grant_id;
   logic           busy;

   axis_pkt_arbiter_if #(.AXIS_DW(DW), .NUM_PORTS(NP)) bus ();

   axis_pkt_arbiter #(.AXIS_DW(DW), .NUM_PORTS(NP)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- sources, model, scoreboard ----------------
   // Beats are packed as {data, keep, last}.
   logic [BW-1:0]  src_q [NP][$];
   logic [BW-1:0]  exp_q[$];
   logic [NP-1:0]  src_en;
   bit             rand_ready;
   bit             rand_gap;
   bit             m_busy;
   int             m_g;
   int             m_last;
   int             checks;
   int             errors;
   int             hs_count;
   int             grant_log[$];
   bit             busy_log[$];
   bit             mv_log[$];
   logic [NP-1:0]  v_log[$];
   int             on_runs[$];
   int             gap_runs[$];

   function automatic int rr_pick(logic [NP-1:0] v, int last);
      for (int k = 1; k <= NP; k++) begin
         if (v[(last + k) % NP]) return (last + k) % NP;
      end
      return -1;
   endfunction

   function automatic bit pending();
      for (int i = 0; i < NP; i++) if (src_q[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic push_beat(int p, logic [KW-1:0] k, logic l);
      logic [DW-1:0] d;
      d = {$urandom, $urandom};
      src_q[p].push_back({d, k, l});
   endtask

   task automatic add_pkt(int p, int len);
      for (int b = 0; b < len; b++) push_beat(p, KW'($urandom), (b == len - 1));
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NP; i++) begin
         if (rand_gap) src_en[i] = ($urandom_range(0, 3) != 0);
         bus.s_axis_tvalid[i] = src_en[i] && (src_q[i].size() != 0);
         if (src_q[i].size() != 0) begin
            bus.s_axis_tdata[i*DW +: DW] = src_q[i][0][BW-1 -: DW];
            bus.s_axis_tkeep[i*KW +: KW] = src_q[i][0][KW:1];
            bus.s_axis_tlast[i]          = src_q[i][0][0];
         end else begin
            bus.s_axis_tdata[i*DW +: DW] = '0;
            bus.s_axis_tkeep[i*KW +: KW] = '0;
            bus.s_axis_tlast[i]          = 1'b0;
         end
      end
      bus.m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic clear_all();
      for (int i = 0; i < NP; i++) src_q[i].delete();
      exp_q.delete();
      grant_log.delete();
      busy_log.delete();
      mv_log.delete();
      v_log.delete();
      drive_inputs();
   endtask

   // One clock: compare outputs with the model at negedge, then advance model and sources.
   task automatic step();
      logic [NP-1:0] v;
      logic [NP-1:0] exp_rdy;
      logic [BW-1:0] got;
      logic [BW-1:0] want;
      bit            exp_mv;
      bit            lastb;
      int            p;
      @(negedge clk);
      v = bus.s_axis_tvalid;
      if (rst) begin
         m_busy = 1'b0;
         m_last = NP - 1;
      end
      exp_mv  = m_busy && v[m_g];
      exp_rdy = '0;
      if (m_busy) exp_rdy[m_g] = bus.m_axis_tready;
      checks++;
      if (bus.m_axis_tvalid !== exp_mv) begin
         errors++;
         $display("FAIL m_tvalid got %b want %b t=%0t", bus.m_axis_tvalid, exp_mv, $time);
      end
      checks++;
      if (bus.s_axis_tready !== exp_rdy) begin
         errors++;
         $display("FAIL s_tready got %b want %b t=%0t", bus.s_axis_tready, exp_rdy, $time);
      end
      checks++;
      if (busy !== m_busy) begin
         errors++;
         $display("FAIL busy got %b want %b t=%0t", busy, m_busy, $time);
      end
      checks++;
      if (grant_id !== IDW'(m_busy ? m_g : m_last)) begin
         errors++;
         $display("FAIL grant_id got %0d want %0d t=%0t", grant_id, (m_busy ? m_g : m_last), $time);
      end
      got = {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast};
      if (exp_mv) begin
         checks++;
         if (got !== src_q[m_g][0]) begin
            errors++;
            $display("FAIL passthru got %h want %h t=%0t", got, src_q[m_g][0], $time);
         end
      end
      busy_log.push_back(busy);
      mv_log.push_back(bus.m_axis_tvalid);
      v_log.push_back(v);
      if (exp_mv && bus.m_axis_tready) begin
         hs_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_order got %h want none t=%0t", got, $time);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               errors++;
               $display("FAIL beat_order got %h want %h t=%0t", got, want, $time);
            end
         end
         lastb = src_q[m_g][0][0];
         void'(src_q[m_g].pop_front());
         if (lastb) begin
            m_busy = 1'b0;
            m_last = m_g;
         end
      end else if (!m_busy && !rst && (|v)) begin
         p = rr_pick(v, m_last);
         m_busy = 1'b1;
         m_g    = p;
         grant_log.push_back(p);
         for (int b = 0; b < src_q[p].size(); b++) begin
            exp_q.push_back(src_q[p][b]);
            if (src_q[p][b][0]) break;
         end
      end
      @(posedge clk);
      #1;
      drive_inputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      clear_all();
   endtask

   task automatic run_until_drained(int budget);
      int n;
      n = 0;
      while ((pending() || m_busy) && (n < budget)) begin
         step();
         n++;
      end
      step();
      checks++;
      if (pending() || m_busy) begin
         errors++;
         $display("FAIL drain_timeout got %0d cycles want <%0d", n, budget);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_beats got %0d want 0", exp_q.size());
      end
   endtask

   task automatic analyze_busy();
      int on;
      int off;
      bit seen;
      on = 0;
      off = 0;
      seen = 1'b0;
      on_runs.delete();
      gap_runs.delete();
      foreach (busy_log[i]) begin
         if (busy_log[i]) begin
            if (seen && (off > 0)) gap_runs.push_back(off);
            off = 0;
            on++;
            seen = 1'b1;
         end else begin
            if (on > 0) on_runs.push_back(on);
            on = 0;
            off++;
         end
      end
      if (on > 0) on_runs.push_back(on);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      for (int p = 0; p < NP; p++) add_pkt(p, 2);
      drive_inputs();
      step();
      step();
      step();
      checks++;
      if (grant_id !== IDW'(NP - 1)) begin
         errors++;
         $display("FAIL reset_grant_id got %0d want %0d", grant_id, NP - 1);
      end
      foreach (busy_log[i]) begin
         checks++;
         if (busy_log[i] !== 1'b0 || mv_log[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b mv=%b want 0/0", busy_log[i], mv_log[i]);
         end
      end
      clear_all();
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_port();
      int first_v;
      int first_mv;
      int nbusy;
      do_reset();
      push_beat(2, 8'hC0, 1'b0);
      push_beat(2, 8'hFF, 1'b0);
      push_beat(2, 8'h03, 1'b1);
      drive_inputs();
      run_until_drained(50);
      first_v = -1;
      first_mv = -1;
      nbusy = 0;
      foreach (v_log[i]) begin
         if (first_v < 0 && v_log[i][2]) first_v = i;
         if (first_mv < 0 && mv_log[i]) first_mv = i;
         if (busy_log[i]) nbusy++;
      end
      checks++;
      if (first_mv - first_v !== 1) begin
         errors++;
         $display("FAIL grant_latency got %0d want 1", first_mv - first_v);
      end
      checks++;
      if (grant_log.size() != 1 || grant_log[0] != 2) begin
         errors++;
         $display("FAIL single_grant got n=%0d g=%0d want n=1 g=2", grant_log.size(),
                  (grant_log.size() != 0) ? grant_log[0] : -1);
      end
      checks++;
      if (nbusy != 3 || busy_log[busy_log.size()-1] !== 1'b0) begin
         errors++;
         $display("FAIL single_xfer_cycles got %0d want 3 then idle", nbusy);
      end
   endtask

   task automatic test_two_ports();
      int want[3];
      want = '{0, 3, 0};
      do_reset();
      add_pkt(0, 2);
      add_pkt(3, 2);
      add_pkt(0, 2);
      drive_inputs();
      run_until_drained(100);
      analyze_busy();
      checks++;
      if (grant_log.size() != 3) begin
         errors++;
         $display("FAIL two_port_count got %0d want 3", grant_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (grant_log[i] != want[i]) begin
               errors++;
               $display("FAIL two_port_order[%0d] got %0d want %0d", i, grant_log[i], want[i]);
            end
         end
      end
      foreach (gap_runs[i]) begin
         checks++;
         if (gap_runs[i] != 1) begin
            errors++;
            $display("FAIL two_port_bubble got %0d want 1", gap_runs[i]);
         end
      end
   endtask

   task automatic test_round_robin();
      int want[5];
      want = '{0, 1, 2, 3, 0};
      do_reset();
      for (int p = 0; p < NP; p++) add_pkt(p, 2);
      add_pkt(0, 2);
      drive_inputs();
      run_until_drained(100);
      analyze_busy();
      checks++;
      if (grant_log.size() != 5 || on_runs.size() != 5 || gap_runs.size() != 4) begin
         errors++;
         $display("FAIL rr_count got g=%0d on=%0d gap=%0d want 5/5/4",
                  grant_log.size(), on_runs.size(), gap_runs.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (grant_log[i] != want[i] || on_runs[i] != 2 || (i < 4 && gap_runs[i] != 1)) begin
               errors++;
               $display("FAIL rr_packet[%0d] got g=%0d on=%0d want g=%0d 3-cycle packet",
                        i, grant_log[i], on_runs[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_random_stream();
      do_reset();
      rand_ready = 1'b1;
      rand_gap   = 1'b1;
      for (int k = 0; k < 24; k++) add_pkt($urandom_range(0, NP - 1), $urandom_range(1, 5));
      drive_inputs();
      run_until_drained(3000);
      checks++;
      if (grant_log.size() != 24) begin
         errors++;
         $display("FAIL random_packets got %0d want 24", grant_log.size());
      end
      rand_ready = 1'b0;
      rand_gap   = 1'b0;
      src_en     = '1;
      drive_inputs();
   endtask

   task automatic test_reset_mid_packet();
      int hs0;
      int n;
      do_reset();
      add_pkt(1, 4);
      drive_inputs();
      hs0 = hs_count;
      n = 0;
      while (hs_count < hs0 + 1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (hs_count != hs0 + 1) begin
         errors++;
         $display("FAIL mid_reset_setup got %0d beats want 1", hs_count - hs0);
      end
      rst = 1'b1;
      step();
      checks++;
      if (busy_log[busy_log.size()-1] !== 1'b0 || mv_log[mv_log.size()-1] !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle got busy=%b mv=%b want 0/0",
                  busy_log[busy_log.size()-1], mv_log[mv_log.size()-1]);
      end
      rst = 1'b0;
      clear_all();
      add_pkt(1, 2);
      add_pkt(2, 2);
      drive_inputs();
      run_until_drained(100);
      checks++;
      if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 2) begin
         errors++;
         $display("FAIL post_reset_order got n=%0d first=%0d want 1 then 2", grant_log.size(),
                  (grant_log.size() != 0) ? grant_log[0] : -1);
      end
   endtask

   task automatic test_single_beat();
      do_reset();
      for (int k = 0; k < 3; k++) push_beat(1, '0, 1'b1);
      drive_inputs();
      run_until_drained(50);
      analyze_busy();
      checks++;
      if (on_runs.size() != 3) begin
         errors++;
         $display("FAIL single_beat_count got %0d want 3", on_runs.size());
      end
      foreach (on_runs[i]) begin
         checks++;
         if (on_runs[i] != 1) begin
            errors++;
            $display("FAIL single_beat_xfer got %0d cycles want 1", on_runs[i]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks   = 0;
      errors   = 0;
      hs_count = 0;
      m_busy   = 1'b0;
      m_g      = 0;
      m_last   = NP - 1;
      src_en   = '1;
      rand_ready = 1'b0;
      rand_gap   = 1'b0;
      drive_inputs();
      test_reset();
      test_single_port();
      test_two_ports();
      test_round_robin();
      test_random_stream();
      test_reset_mid_packet();
      test_single_beat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axis_pkt_arbiter.md
AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 Parameter AXIS_DW, default 64, SHALL set the data width per port, in bits.
REQ-002 Parameter NUM_PORTS, default 4, range 2..8, SHALL set the number of AXIS slave ports.
REQ-003 Localparam AXIS_KW SHALL equal ((AXIS_DW-1)>>3)+1; localparam IDW SHALL equal $clog2(NUM_PORTS).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port list:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tready  out  NUM_PORTS  per-port ready
- s_axis_tdata  in  NUM_PORTS*AXIS_DW  port i at [i*AXIS_DW +: AXIS_DW]
- s_axis_tkeep  in  NUM_PORTS*AXIS_KW  port i at [i*AXIS_KW +: AXIS_KW]
- s_axis_tlast  in  NUM_PORTS  per-port last
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready, for example from a downstream axis_align
- m_axis_tdata  out  AXIS_DW  output data
- m_axis_tkeep  out  AXIS_KW  output keep
- m_axis_tlast  out  1  output last
- grant_id  out  IDW  index of the granted port
- busy  out  1  high while a packet is locked

Function
REQ-006 The FSM SHALL have exactly two states, IDLE and XFER, and a last_grant register of width IDW.
REQ-007 In IDLE with any s_axis_tvalid high, the block SHALL register the new grant as the first port with tvalid high, searching (last_grant+1) mod NUM_PORTS upward with wrap-around.
REQ-008 The block SHALL enter XFER on the next clock edge; arbitration latency SHALL be exactly 1 cycle from the first observed tvalid to m_axis_tvalid.
REQ-009 In IDLE, m_axis_tvalid SHALL be 0, all s_axis_tready bits SHALL be 0, and busy SHALL be 0.
REQ-010 In XFER with grant g:
- m_axis_tvalid/tdata/tkeep/tlast SHALL equal port g's inputs combinationally.
- s_axis_tready[g] SHALL equal m_axis_tready.
- All other s_axis_tready bits SHALL be 0.
- busy SHALL be 1.
REQ-011 Beats SHALL pass unmodified, including tkeep values that are all-zero or non-contiguous; the block SHALL NOT inspect tkeep.
REQ-012 On a handshake (m_axis_tvalid & m_axis_tready) with m_axis_tlast=1, the block SHALL return to IDLE and load last_grant with g.
REQ-013 There SHALL be one bubble cycle between packets.
REQ-014 The grant SHALL hold through the whole packet regardless of other ports' tvalid.
REQ-015 If port g deasserts tvalid mid-packet, the block SHALL stay in XFER with m_axis_tvalid=0; there SHALL be no timeout and no re-arbitration.
REQ-016 The block SHALL NOT enforce the AXIS rule that a port must not retract tvalid; a retraction SHALL appear at the output as-is.
REQ-017 grant_id SHALL show the registered grant in XFER and last_grant in IDLE.
REQ-018 A single-beat packet (tlast on the first beat) SHALL occupy XFER for exactly one handshake cycle.
REQ-019 Under continuous requests from all ports with m_axis_tready held at 1, grants SHALL rotate 0,1,...,NUM_PORTS-1,0 with no port starved.

Reset
REQ-020 While rst=1 at a clock edge, the state SHALL become IDLE and last_grant SHALL become NUM_PORTS-1, so that port 0 has first priority after reset.
REQ-021 During reset, all outputs SHALL follow the IDLE values: m_axis_tvalid=0, s_axis_tready=0, busy=0, grant_id=NUM_PORTS-1.
REQ-022 Reset asserted mid-packet SHALL abandon the packet without generating tlast; the next grant after reset SHALL follow REQ-007.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset release with only port 2 valid, packet of 3 beats with tkeep C0,FF,03 and m_axis_tready=1 -> m_axis_tvalid rises 1 cycle after tvalid; grant_id=2; 3 beats pass unchanged; IDLE after the tlast beat.
- Ports 0 and 3 valid simultaneously after reset -> port 0 granted first, then port 3 after one bubble cycle, then port 0.
- All 4 ports each sending 2-beat packets, m_axis_tready=1 -> grant sequence 0,1,2,3,0; every packet takes 3 cycles.
- Random m_axis_tready with the granted port streaming -> no beat lost or duplicated; s_axis_tready of non-granted ports stays 0 throughout.
- rst pulsed on beat 2 of a 4-beat packet from port 1 -> outputs return to IDLE values; with ports 1 and 2 then valid, port 0 is not valid, so port 1 is granted.
- Single-beat packets with tkeep=00 on port 1 -> forwarded with tlast=1; FSM in XFER for exactly one cycle.
